// File: rtl/encap_pkg.sv
// 48-byte UDP encapsulation header shared by the tx and rx datapaths.
package encap_pkg;
  localparam int ENCAP_BEATS = 6;

  typedef struct packed {
    ethernet_pkg::ethhdr eth;
    ip_pkg::iphdr        ip;
    udp_pkg::udphdr      udp;
    logic [47:0]         pad;
  } encap_hdr_t;

  // raw[5] holds beat 0 so the struct's first field lands on the first bytes.
  typedef union packed {
    logic [ENCAP_BEATS-1:0][63:0] raw;
    encap_hdr_t                   hdr;
  } encap_t;
endpackage

// File: rtl/endian_pkg.sv
// Byte-order helpers: bus byte 0 sits on [7:0], network-order fields want it on top.
package endian_pkg;
  function automatic logic [63:0] endian_conv64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ethernet_pkg.sv
// Ethernet II header layout and constants, fields in network byte order.
package ethernet_pkg;
  localparam logic [15:0] ETH_P_IP    = 16'h0800;
  localparam int          ETH_HDR_LEN = 14;

  typedef struct packed {
    logic [47:0] h_dest;
    logic [47:0] h_source;
    logic [15:0] h_proto;
  } ethhdr;
endpackage

// File: rtl/ip_pkg.sv
// IPv4 header layout (no options) and constants, fields in network byte order.
package ip_pkg;
  localparam logic [3:0] IPVERSION     = 4'd4;
  localparam logic [7:0] IP4_PROTO_UDP = 8'd17;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [15:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] check;
    logic [31:0] saddr;
    logic [31:0] daddr;
  } iphdr;
endpackage

// File: rtl/udp_pkg.sv
// UDP header layout, fields in network byte order.
package udp_pkg;
  typedef struct packed {
    logic [15:0] source;
    logic [15:0] dest;
    logic [15:0] len;
    logic [15:0] check;
  } udphdr;
endpackage

// File: rtl/eth_decap.sv
// Strips the 6-beat Eth/IPv4/UDP header and forwards matching payload to the TLP FIFO.
// Payload passes through combinationally; tready follows !full in payload, header/drop never stall.
module eth_decap
  import ethernet_pkg::*;
  import ip_pkg::*;
  import endian_pkg::*;
  import encap_pkg::*;
#(
  parameter logic [47:0] eth_addr = 48'h00_11_22_33_44_55,
  parameter logic [31:0] ip_addr  = {8'd192, 8'd168, 8'd1, 8'd111},
  parameter logic [15:0] udp_port = 16'd3776
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  output logic [31:0] rx_pkt_cnt,
  output logic [31:0] rx_drop_cnt
);
  typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DROP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic        match_q, match_d;
  encap_t      hdr_q, hdr_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        accept;

  always_comb begin
    s_axis_tready = sys_rst_n && ((state_q != RX_DATA) || !full);
    accept        = s_axis_tvalid && s_axis_tready;
    wr_en         = (state_q == RX_DATA) && s_axis_tvalid && !full;
    din           = {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser};

    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    match_d    = match_q;
    hdr_d      = hdr_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      RX_HDR: begin
        if (accept) begin
          if (hdr_cnt_q <= 3'd4) hdr_d.raw[3'd5 - hdr_cnt_q] = endian_conv64(s_axis_tdata);
          // Beat 4 carries the UDP dest port, so the verdict uses the merged view.
          if (hdr_cnt_q == 3'd4) begin
            match_d = (hdr_d.hdr.eth.h_dest == eth_addr)
                   && (hdr_d.hdr.eth.h_proto == ETH_P_IP)
                   && (hdr_d.hdr.ip.version == IPVERSION)
                   && (hdr_d.hdr.ip.ihl == 4'd5)
                   && (hdr_d.hdr.ip.protocol == IP4_PROTO_UDP)
                   && (hdr_d.hdr.ip.daddr == ip_addr)
                   && (hdr_d.hdr.udp.dest == udp_port);
          end
          if (s_axis_tlast) begin
            hdr_cnt_d  = 3'd0;
            drop_cnt_d = drop_cnt_q + 32'd1;
          end else if (hdr_cnt_q == 3'd5) begin
            hdr_cnt_d = 3'd0;
            state_d   = match_q ? RX_DATA : RX_DROP;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end
      RX_DATA: begin
        if (accept && s_axis_tlast) begin
          state_d   = RX_HDR;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
      end
      RX_DROP: begin
        if (accept && s_axis_tlast) begin
          state_d    = RX_HDR;
          drop_cnt_d = drop_cnt_q + 32'd1;
        end
      end
      default: state_d = RX_HDR;
    endcase
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= RX_HDR;
      hdr_cnt_q  <= 3'd0;
      match_q    <= 1'b0;
      hdr_q      <= '0;
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      match_q    <= match_d;
      hdr_q      <= hdr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_pkt_cnt  = pkt_cnt_q;
  assign rx_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_eth_decap.sv
// Directed + randomized bench for eth_decap; expected FIFO words come from a byte-level frame model.
module tb_eth_decap;
  localparam logic [47:0] MAC  = 48'h00_11_22_33_44_55;
  localparam logic [31:0] IPA  = {8'd192, 8'd168, 8'd1, 8'd111};
  localparam logic [15:0] PORT = 16'd3776;

  logic        clk156 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        wr_en;
  logic [73:0] din;
  logic        full = 1'b0;
  logic [31:0] rx_pkt_cnt;
  logic [31:0] rx_drop_cnt;

  always #5 clk156 = ~clk156;

  eth_decap dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .wr_en(wr_en), .din(din), .full(full),
    .rx_pkt_cnt(rx_pkt_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  frm[$];
  logic        frm_user;
  logic [73:0] got_q[$];
  logic [73:0] exp_q[$];
  logic [31:0] exp_pkt = 0;
  logic [31:0] exp_drop = 0;
  int          beats_acc = 0;
  bit          abort = 0;
  bit          full_rand = 0;
  logic        full_force = 1'b0;

  // full only ever changes just after a rising edge
  always begin
    @(posedge clk156);
    #1;
    full = full_rand ? ($urandom_range(3) == 0) : full_force;
  end

  always @(negedge clk156) if (wr_en === 1'b1) got_q.push_back(din);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [73:0] beat_word(input int b);
    int n, nb;
    logic [63:0] d;
    logic [7:0] k;
    logic last;
    n = frm.size();
    nb = (n + 7) / 8;
    d = '0;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      if (8*b + i < n) begin
        d[8*i +: 8] = frm[8*b + i];
        k[i] = 1'b1;
      end
    end
    last = (b == nb - 1);
    return {k, d, last, last ? frm_user : 1'b0};
  endfunction

  task automatic setb(input int i, input logic [7:0] v);
    if (i < frm.size()) frm[i] = v;
  endtask

  task automatic xorb(input int i);
    if (i < frm.size()) frm[i] = frm[i] ^ 8'($urandom_range(1, 255));
  endtask

  // bad: 0 good, 1 MAC, 2 ethertype, 3 version/ihl, 4 protocol, 5 dst IP, 6 UDP port 53
  task automatic make_frame(input int len, input int bad);
    logic [47:0] mac_v;
    logic [31:0] ip_v;
    logic [15:0] port_v;
    mac_v = MAC;
    ip_v = IPA;
    port_v = PORT;
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(255)));
    frm_user = 1'b0;
    for (int i = 0; i < 6; i++) setb(i, mac_v[8*(5-i) +: 8]);
    setb(12, 8'h08); setb(13, 8'h00); setb(14, 8'h45); setb(23, 8'd17);
    for (int i = 0; i < 4; i++) setb(30 + i, ip_v[8*(3-i) +: 8]);
    setb(36, port_v[15:8]); setb(37, port_v[7:0]);
    case (bad)
      1: xorb($urandom_range(5));
      2: xorb(12 + $urandom_range(1));
      3: xorb(14);
      4: xorb(23);
      5: xorb(30 + $urandom_range(3));
      6: begin setb(36, 8'd0); setb(37, 8'd53); end
      default: ;
    endcase
  endtask

  task automatic model_frame();
    int n, nb;
    bit ok;
    n = frm.size();
    nb = (n + 7) / 8;
    if (nb <= 6) begin
      exp_drop++;
    end else begin
      ok = 1;
      for (int i = 0; i < 6; i++) if (frm[i] != MAC[8*(5-i) +: 8]) ok = 0;
      if (frm[12] != 8'h08 || frm[13] != 8'h00 || frm[14] != 8'h45 || frm[23] != 8'd17) ok = 0;
      for (int i = 0; i < 4; i++) if (frm[30+i] != IPA[8*(3-i) +: 8]) ok = 0;
      if ({frm[36], frm[37]} != PORT) ok = 0;
      if (ok) begin
        for (int b = 6; b < nb; b++) exp_q.push_back(beat_word(b));
        exp_pkt++;
      end else begin
        exp_drop++;
      end
    end
  endtask

  task automatic send_frame(input int gap_pct, input bit hold_valid);
    int nb, waited;
    logic [73:0] w;
    logic acc;
    nb = (frm.size() + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk156);
        #1;
      end
      w = beat_word(b);
      {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser} = w;
      s_axis_tvalid = 1'b1;
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge clk156);
        acc = s_axis_tready;
        @(posedge clk156);
        if (abort) begin
          #1;
          s_axis_tvalid = 1'b0;
          return;
        end
        waited++;
        if (waited > 1000) begin
          check("accept_timeout", {73'd0, acc}, 74'd1);
          #1;
          s_axis_tvalid = 1'b0;
          return;
        end
      end
      beats_acc++;
      #1;
    end
    if (!hold_valid) s_axis_tvalid = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk156);
    #1;
  endtask

  task automatic compare_out(input string tag);
    int n;
    check({tag, "_nwrites"}, 74'(got_q.size()), 74'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_din"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    check({tag, "_pkt_cnt"}, 74'(rx_pkt_cnt), 74'(exp_pkt));
    check({tag, "_drop_cnt"}, 74'(rx_drop_cnt), 74'(exp_drop));
  endtask

  initial begin
    // reset state
    @(negedge clk156);
    check("rst_tready", 74'(s_axis_tready), 74'd0);
    check("rst_wr_en", 74'(wr_en), 74'd0);
    check("rst_pkt_cnt", 74'(rx_pkt_cnt), 74'd0);
    check("rst_drop_cnt", 74'(rx_drop_cnt), 74'd0);
    @(negedge clk156);
    sys_rst_n = 1'b1;
    @(posedge clk156);
    #1;
    check("idle_tready", 74'(s_axis_tready), 74'd1);

    // wrong UDP port is dropped
    make_frame(60, 6); model_frame(); send_frame(0, 0); settle();
    check("udp53_drop", 74'(rx_drop_cnt), 74'd1);
    check("udp53_pkt", 74'(rx_pkt_cnt), 74'd0);
    compare_out("udp53");

    // matching 60-byte frame: two payload writes
    make_frame(60, 0); model_frame(); send_frame(0, 0); settle();
    check("m60_nwr", 74'(got_q.size()), 74'd2);
    if (got_q.size() == 2) begin
      check("m60_keep0", 74'(got_q[0][73:66]), 74'hFF);
      check("m60_keep1", 74'(got_q[1][73:66]), 74'h0F);
      check("m60_last1", 74'(got_q[1][1]), 74'd1);
    end
    check("m60_pkt", 74'(rx_pkt_cnt), 74'd1);
    compare_out("m60");

    // runt followed immediately by a good frame carrying tuser
    make_frame(24, 0); model_frame(); send_frame(0, 1);
    make_frame(56, 0); frm_user = 1'b1; model_frame(); send_frame(0, 0); settle();
    compare_out("runt");

    // full held during payload beat 0
    full_force = 1'b1;
    @(posedge clk156);
    #2;
    make_frame(72, 0); model_frame(); beats_acc = 0;
    fork
      send_frame(0, 0);
      begin
        for (int i = 0; i < 400; i++) begin
          @(posedge clk156);
          #2;
          if (beats_acc == 6) break;
        end
        check("hold_reach_payload", 74'(beats_acc), 74'd6);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk156);
          check("hold_tready", 74'(s_axis_tready), 74'd0);
          check("hold_wr_en", 74'(wr_en), 74'd0);
        end
        full_force = 1'b0;
      end
    join
    settle();
    compare_out("hold");

    // randomized mix: lengths, bad fields, gaps, full, tuser
    full_rand = 1;
    for (int f = 0; f < 40; f++) begin
      make_frame($urandom_range(1, 100), ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 6));
      frm_user = 1'($urandom_range(1));
      model_frame();
      send_frame(30, 0);
    end
    full_rand = 0;
    settle();
    compare_out("rand");

    // clean counters, then 100 back-to-back frames
    @(negedge clk156); sys_rst_n = 1'b0;
    @(negedge clk156); sys_rst_n = 1'b1;
    @(posedge clk156); #1;
    exp_pkt = 0; exp_drop = 0;
    for (int f = 0; f < 100; f++) begin
      make_frame(64, 0); model_frame(); send_frame(0, 1);
    end
    s_axis_tvalid = 1'b0;
    settle();
    check("b2b_writes", 74'(got_q.size()), 74'd200);
    check("b2b_pkt", 74'(rx_pkt_cnt), 74'd100);
    compare_out("b2b");

    // reset during payload beat 1
    make_frame(72, 0); beats_acc = 0; abort = 0;
    fork
      send_frame(0, 0);
      begin
        for (int i = 0; i < 400; i++) begin
          @(posedge clk156);
          #2;
          if (beats_acc == 7) break;
        end
        check("rstmid_reach", 74'(beats_acc), 74'd7);
        sys_rst_n = 1'b0;
        abort = 1;
        @(negedge clk156);
        check("rstmid_tready", 74'(s_axis_tready), 74'd0);
        check("rstmid_wr_en", 74'(wr_en), 74'd0);
        check("rstmid_pkt", 74'(rx_pkt_cnt), 74'd0);
        check("rstmid_drop", 74'(rx_drop_cnt), 74'd0);
        repeat (2) @(negedge clk156);
        sys_rst_n = 1'b1;
      end
    join
    abort = 0;
    exp_q.push_back(beat_word(6));
    exp_pkt = 0; exp_drop = 0;
    settle();
    compare_out("rstmid");

    // fresh frame after reset
    make_frame(60, 0); model_frame(); send_frame(0, 0); settle();
    check("fresh_pkt", 74'(rx_pkt_cnt), 74'd1);
    compare_out("fresh");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/eth_decap.md
ETH_DECAP -- requirements
Module: eth_decap

Interface
REQ-001 SHALL have parameter eth_addr, default 48'h00_11_22_33_44_55, local MAC address to accept.
REQ-002 SHALL have parameter ip_addr, default {8'd192,8'd168,8'd1,8'd111}, local IPv4 address to accept.
REQ-003 SHALL have parameter udp_port, default 16'd3776, UDP destination port to accept.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset; all state is cleared asynchronously on reset assertion and released synchronously to clk156.
REQ-005 SHALL have ports:
  clk156  in  1  system clock;
  sys_rst_n  in  1  async active-low reset;
  s_axis_tvalid  in  1  MAC rx valid;
  s_axis_tready  out  1  MAC rx ready;
  s_axis_tdata  in  64  rx data, byte 0 of the beat on bits [7:0];
  s_axis_tkeep  in  8  byte enables;
  s_axis_tlast  in  1  end of frame;
  s_axis_tuser  in  1  frame error, valid on tlast;
  wr_en  out  1  TLP FIFO write strobe;
  din  out  74  FIFO word {tkeep[7:0], tdata[63:0], tlast, tuser};
  full  in  1  TLP FIFO full;
  rx_pkt_cnt  out  32  frames forwarded;
  rx_drop_cnt  out  32  frames discarded.

Function
REQ-006 SHALL treat beats 0-5 of every frame (48 B: 14 B Ethernet, 20 B IPv4, 8 B UDP, 6 B pad) as encapsulation header, never written to the FIFO.
REQ-007 SHALL use FSM states RX_HDR, RX_DATA, RX_DROP plus 3-bit hdr_cnt (0-5); a beat is accepted when s_axis_tvalid && s_axis_tready.
REQ-008 SHALL drive s_axis_tready=1 in RX_HDR and RX_DROP, s_axis_tready=!full in RX_DATA, and s_axis_tready=0 while sys_rst_n is low.
REQ-009 SHALL capture accepted beats 0-4 byte-swapped into the shared header union so field compares use network-order field values.
REQ-010 SHALL register match=1 on acceptance of beat 4 iff h_dest==eth_addr, h_proto==ETH_P_IP, version==4, ihl==5, protocol==IP4_PROTO_UDP, daddr==ip_addr, and udp dest==udp_port.
REQ-011 SHALL, on acceptance of beat 5 without tlast, move to RX_DATA if match, else to RX_DROP, and reset hdr_cnt to 0.
REQ-012 SHALL, on any accepted header beat carrying tlast (runt frame), stay in RX_HDR, clear hdr_cnt, and increment rx_drop_cnt once.
REQ-013 SHALL, in RX_DATA, assert wr_en=s_axis_tvalid && !full combinationally, with din={s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser}, without byte swapping the payload.
REQ-014 SHALL, on the accepted tlast beat in RX_DATA, return to RX_HDR and increment rx_pkt_cnt, including frames with tuser=1, whose error is forwarded in din[0].
REQ-015 SHALL, in RX_DROP, consume beats without asserting wr_en, and on the accepted tlast beat return to RX_HDR and increment rx_drop_cnt.
REQ-016 SHALL hold the beat and assert no wr_en while full=1 in RX_DATA, with zero-cycle pass-through latency once full deasserts.
REQ-017 SHALL let both counters wrap modulo 2^32.
REQ-018 SHALL deassert wr_en in all states other than RX_DATA.
REQ-019 SHALL support back-to-back frames: the beat following a tlast is header beat 0 of the next frame, with no idle cycle.

Reset
REQ-020 SHALL, on sys_rst_n low, force state=RX_HDR, hdr_cnt=0, match=0, wr_en=0, s_axis_tready=0, and both counters to 0.
REQ-021 SHALL, on reset asserted mid-frame, abandon the frame; after release, the next accepted beat is treated as header beat 0.

Structure
REQ-022 SHALL take ethhdr, iphdr, udphdr, ETH_P_IP, IPVERSION, IP4_PROTO_UDP, and ETH_HDR_LEN from the existing ethernet_pkg, ip_pkg, and udp_pkg.
REQ-023 SHALL use a 48-byte encap header union (raw 6x64 / eth, ip, udp, pad struct) moved into a shared encap_pkg for use by both transmit and receive sides.
REQ-024 SHALL use endian_conv64 from endian_pkg for header byte swapping, with no sub-module; the block is a single FSM module.

Verification
REQ-025 SHALL verify: a matching 60 B frame (6 header beats + 2 payload beats, last tkeep=8'h0F) produces exactly 2 wr_en pulses with din[73:66]=8'hFF then 8'h0F, din[1]=1 on the second, and rx_pkt_cnt=1.
REQ-026 SHALL verify: a frame with udp dest=16'd53 produces no wr_en, and rx_drop_cnt=1, rx_pkt_cnt=0.
REQ-027 SHALL verify: a 3-beat runt frame with tlast on beat 2 produces no wr_en and rx_drop_cnt=1, and the following valid frame is forwarded intact.
REQ-028 SHALL verify: with full=1 held for 5 cycles during payload beat 0, s_axis_tready=0 and wr_en=0 throughout, then payload is written in order with no loss or duplication.
REQ-029 SHALL verify: 100 back-to-back matching frames with tvalid always 1 give rx_pkt_cnt=100 and 200 FIFO writes.
REQ-030 SHALL verify: sys_rst_n pulsed low during payload beat 1 gives counters=0, then a fresh matching frame forwards normally.
